// File: rtl/prog_sequence_generator_if.sv
// Bundles the table write port, sequence control and output handshake
// of prog_sequence_generator.
interface prog_sequence_generator_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] len;
  logic [1:0]        mode;
  logic              start;
  logic              stop;
  logic              enable;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data, len, mode, start, stop, enable, out_ready,
    input  out_valid, data, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len, mode, start, stop, enable, out_ready,
    output out_valid, data, busy, done
  );
endinterface

// File: rtl/prog_sequence_generator.sv
// Programmable sequence generator: replays a register table in loop,
// one-shot or ping-pong order through a valid/ready output register.
module prog_sequence_generator #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  prog_sequence_generator_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_e;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] table_q [DEPTH];
  logic [DATA_W-1:0] table_d [DEPTH];
  logic              issue;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    dir_d       = dir_q;
    idx_d       = idx_q;
    len_d       = len_q;
    mode_d      = mode_q;
    data_d      = data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    table_d     = table_q;
    issue       = 1'b0;

    if (bus.wr_en) table_d[bus.wr_addr] = bus.wr_data;

    // Stop outranks start; neither control cycle issues a word.
    if (bus.stop) begin
      state_d = IDLE;
    end else if (bus.start) begin
      state_d = RUN;
      idx_d   = '0;
      dir_d   = DIR_UP;
      mode_d  = bus.mode;
      len_d   = bus.len;
    end else if (state_q == RUN) begin
      issue = bus.enable && (!out_valid_q || bus.out_ready);
    end

    if (issue) begin
      // Reads the registered table, so a same-cycle write yields the old word.
      data_d      = table_q[idx_q];
      out_valid_d = 1'b1;
      case (mode_q)
        MODE_ONESHOT: begin
          if (idx_q == len_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
        MODE_PINGPONG: begin
          if (len_q == '0) begin
            idx_d = '0;
          end else if (dir_q == DIR_UP) begin
            if (idx_q == len_q) begin
              dir_d = DIR_DOWN;
              idx_d = idx_q - ADDR_W'(1);
            end else begin
              idx_d = idx_q + ADDR_W'(1);
            end
          end else begin
            if (idx_q == '0) begin
              dir_d = DIR_UP;
              idx_d = ADDR_W'(1);
            end else begin
              idx_d = idx_q - ADDR_W'(1);
            end
          end
        end
        default: idx_d = (idx_q == len_q) ? '0 : idx_q + ADDR_W'(1);
      endcase
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      dir_q       <= DIR_UP;
      idx_q       <= '0;
      len_q       <= '0;
      mode_q      <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      // NOTE: the table is a register file that must clear on reset, so it
      // lives in this reset domain rather than an unreset RAM.
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q     <= state_d;
      dir_q       <= dir_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      table_q     <= table_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.data      = data_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_prog_sequence_generator.sv
// Directed bench for prog_sequence_generator with hand-computed expected words.
module tb_prog_sequence_generator;

  logic clk = 1'b0;
  logic reset_n;
  int   n_pass  = 0;
  int   n_total = 0;

  logic [7:0] vec [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};
  int         pp_idx [9] = '{0, 1, 2, 3, 2, 1, 0, 1, 2};

  prog_sequence_generator_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  prog_sequence_generator #(.DATA_W(8), .DEPTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [7:0] exp);
    check({tag, ".valid"}, {31'b0, bus.out_valid}, 32'd1);
    check({tag, ".data"}, {24'b0, bus.data}, {24'b0, exp});
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.len       = '0;
    bus.mode      = 2'b00;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.enable    = 1'b0;
    bus.out_ready = 1'b0;

    #3;
    check("rst.valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst.data",  {24'b0, bus.data},      32'd0);
    check("rst.busy",  {31'b0, bus.busy},      32'd0);
    check("rst.done",  {31'b0, bus.done},      32'd0);
    step();
    step();
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 3'(i);
      bus.wr_data = vec[i];
      step();
    end
    bus.wr_en = 1'b0;

    // Loop, len=7: full table then wrap, one word per cycle.
    bus.len = 3'd7; bus.mode = 2'b00; bus.enable = 1'b1; bus.out_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("loop.busy_after_start",  {31'b0, bus.busy},      32'd1);
    check("loop.valid_after_start", {31'b0, bus.out_valid}, 32'd0);
    bus.len = 3'd2; bus.mode = 2'b01;  // must not affect the latched run
    for (int k = 0; k < 10; k++) begin
      step();
      check_word($sformatf("loop%0d", k), vec[k % 8]);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("stop.busy",  {31'b0, bus.busy},      32'd0);
    check("stop.done",  {31'b0, bus.done},      32'd0);
    check("stop.valid", {31'b0, bus.out_valid}, 32'd0);

    // Ping-pong, len=3.
    bus.len = 3'd3; bus.mode = 2'b10; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step();
      check_word($sformatf("pp%0d", k), vec[pp_idx[k]]);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;

    // Backpressure on BC for three cycles, then no skipped word.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    check_word("bp.first", 8'hAF);
    step();
    check_word("bp.bc", 8'hBC);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_word($sformatf("bp.hold%0d", k), 8'hBC);
    end
    bus.out_ready = 1'b1;
    step();
    check_word("bp.next", 8'hE2);
    step();
    check_word("bp.after", 8'h78);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;

    // One-shot, len=2.
    bus.len = 3'd2; bus.mode = 2'b01; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    check_word("os.w0", 8'hAF);
    check("os.w0.done", {31'b0, bus.done}, 32'd0);
    step();
    check_word("os.w1", 8'hBC);
    check("os.w1.done", {31'b0, bus.done}, 32'd0);
    step();
    check_word("os.w2", 8'hE2);
    check("os.w2.done", {31'b0, bus.done}, 32'd1);
    check("os.w2.busy", {31'b0, bus.busy}, 32'd0);
    step();
    check("os.end.done",  {31'b0, bus.done},      32'd0);
    check("os.end.valid", {31'b0, bus.out_valid}, 32'd0);
    check("os.end.busy",  {31'b0, bus.busy},      32'd0);

    // Simultaneous start and stop while running: stop wins, no done.
    bus.len = 3'd7; bus.mode = 2'b00; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    check_word("ss.w0", 8'hAF);
    bus.start = 1'b1; bus.stop = 1'b1;
    step();
    bus.start = 1'b0; bus.stop = 1'b0;
    check("ss.busy",  {31'b0, bus.busy},      32'd0);
    check("ss.done",  {31'b0, bus.done},      32'd0);
    check("ss.valid", {31'b0, bus.out_valid}, 32'd0);
    check("ss.data",  {24'b0, bus.data},      32'hAF);

    // Write idx 0 in the same cycle it is read: old value first.
    bus.len = 3'd1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 8'h55;
    step();
    bus.wr_en = 1'b0;
    check_word("rdw.old", 8'hAF);
    step();
    check_word("rdw.w1", 8'hBC);
    step();
    check_word("rdw.new", 8'h55);

    // Asynchronous reset between edges mid-run.
    bus.len = 3'd7; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    check_word("ar.pre", 8'hBC);
    #3;
    reset_n = 1'b0;
    #1;
    check("ar.valid", {31'b0, bus.out_valid}, 32'd0);
    check("ar.data",  {24'b0, bus.data},      32'd0);
    check("ar.busy",  {31'b0, bus.busy},      32'd0);
    #1;
    reset_n = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("ar.restart_busy", {31'b0, bus.busy}, 32'd1);
    step();
    check_word("ar.tbl0", 8'h00);
    step();
    check_word("ar.tbl1", 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prog_sequence_generator.md
PROG_SEQUENCE_GENERATOR -- requirements
Module: prog_sequence_generator

Interface
REQ-001 Parameter DATA_W, default 8: width of each sequence word and of data.
REQ-002 Parameter DEPTH, default 8: number of sequence entries; SHALL be a power of two and at least 2.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH): width of the index, address and length fields.
REQ-004 clk  in  1: single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  in  1: asynchronous, active-low reset.
REQ-006 wr_en / wr_addr / wr_data  in  1 / ADDR_W / DATA_W: sequence table write port.
REQ-007 len  in  ADDR_W: index of the last entry in the sequence, so the sequence holds len+1 entries.
REQ-008 mode  in  2: 00 loop, 01 one-shot, 10 ping-pong, 11 treated as loop.
REQ-009 start, stop, enable  in  1 each: begin sequence, abort sequence, advance permission.
REQ-010 out_ready  in  1: the consumer accepts data when out_valid is high.
REQ-011 out_valid  out  1: data holds a valid sequence word.
REQ-012 data  out  DATA_W: the registered sequence word.
REQ-013 busy  out  1: high while the FSM is in RUN.
REQ-014 done  out  1: one-cycle pulse after the last one-shot word is issued.

Function
REQ-015 Table: DEPTH x DATA_W registers; wr_en high writes wr_data to wr_addr at the clock edge; writes SHALL be legal in any state.
REQ-016 Read-during-write: a read of the address being written in the same cycle SHALL return the old value.
REQ-017 FSM states are IDLE and RUN; the FSM leaves reset in IDLE.
REQ-018 IDLE to RUN on start: idx<=0, dir<=up, mode and len latched; latched values SHALL be unaffected by later input changes until the next start.
REQ-019 Issue condition: state==RUN and enable and (!out_valid or out_ready).
REQ-020 On issue: data<=table[idx], out_valid<=1, and idx advances per REQ-022 to REQ-024.
REQ-021 If out_valid and out_ready and no issue occurs, out_valid<=0; while out_valid and !out_ready, data and out_valid SHALL hold.
REQ-022 Loop mode: idx wraps from len to 0, giving 0..len,0..len,...
REQ-023 One-shot mode: issuing idx==len moves the FSM to IDLE and pulses done for one cycle; the final word remains held until accepted.
REQ-024 Ping-pong mode: the sequence is 0,1..len,len-1..1,0,1... with endpoints not repeated; dir flips at idx==len when up and at idx==0 when down.
REQ-025 Ping-pong with len==0 SHALL repeat entry 0.
REQ-026 Latency: start at edge N puts busy high after edge N; the first word is valid after edge N+1 if enable is high.
REQ-027 stop in RUN: the FSM goes to IDLE at the next edge with no issue that cycle, done SHALL NOT pulse, and a pending output is held until handshake.
REQ-028 Simultaneous start and stop: stop wins.
REQ-029 start in RUN: restart per REQ-018 with no issue that cycle; a pending output is kept.
REQ-030 enable low freezes idx and dir; a pending output is still drained by out_ready.
REQ-031 Throughput: one word per cycle when enable and out_ready are held high.

Reset
REQ-032 reset_n low SHALL immediately force state=IDLE, idx=0, dir=up, out_valid=0, data=0, busy=0, done=0, latched mode/len=0, and all table entries=0.
REQ-033 Reset release SHALL be honoured at the next clock edge; reset mid-sequence discards all state and any pending output.

Verification
REQ-034 Load the table with AF,BC,E2,78,FF,E2,0B,8D, set len=7, mode=00, start, then hold enable and out_ready high -> data AF..8D then AF repeats, one word per cycle.
REQ-035 Same table, len=3, mode=10 -> AF,BC,E2,78,E2,BC,AF,BC...
REQ-036 mode=01, len=2 -> AF,BC,E2, done pulses once, busy falls, out_valid drops after E2 is accepted.
REQ-037 out_ready low for 3 cycles while data=BC -> data stays BC with out_valid high, and no word is skipped afterwards.
REQ-038 Assert start and stop in the same cycle while running -> IDLE, no done pulse; write 0x55 to idx 0 while it is read -> old value is emitted.
REQ-039 Pulse reset_n low mid-run between clock edges -> out_valid, data and busy go to 0 immediately, and table entries read back as 0.
